// File: rtl/acc_alu_pkg.sv
// Shared op codes, FSM encoding and flag indices for the chunked accumulator ALU.
package acc_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_ADC   = 3'b010,
    OP_SBB   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int FLAG_C    = 0;
  localparam int FLAG_Z    = 1;
  localparam int FLAG_N    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

  // Carry seeded into the first chunk; SBB/ADC chain on the previous op's cf.
  function automatic logic cin_for(input op_e op, input logic cf);
    case (op)
      OP_SUB:         return 1'b1;
      OP_ADC, OP_SBB: return cf;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_chunk.sv
// Combinational CHUNK-bit add/sub/logic slice; zero latency, no flow control.
// ACC_ALU_SIGNED_FLAGS_EN keeps the carry-into-MSB tap used for signed overflow.
module alu_chunk
  import acc_alu_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  op_e              op,
  input  logic             cin,
  output logic [CHUNK-1:0] y,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   sum;

  // op[0] selects inversion for SUB/SBB; only meaningful on the arithmetic ops.
  assign bx  = b ^ {CHUNK{op[0]}};
  assign sum = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        y    = sum[CHUNK-1:0];
        cout = sum[CHUNK];
      end
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_PASSB: y = b;
      default:  y = '0;
    endcase
  end

`ifdef ACC_ALU_SIGNED_FLAGS_EN
  assign c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ bx[CHUNK-1];
`else
  assign c_msb_in = 1'b0;
`endif

endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator ALU computing A <= A op B one CHUNK per clock; start->done = WIDTH/CHUNK cycles.
// Commands accepted only while ready; ACC_ALU_SIGNED_FLAGS_EN enables nf/vf.
module acc_alu_seq
  import acc_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             out_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             ready,
  output logic             done,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e               state, state_nxt;
  op_e                  op_q;
  logic [WIDTH-1:0]     a_q, b_q, s_q, res;
  logic [IW-1:0]        idx;
  logic                 carry_q, zacc_q, done_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [CHUNK-1:0]     a_ch, b_ch, y_ch;
  logic                 cout_ch, cmsb_ch;
  logic                 load_any, last, arith;

  assign load_any = load_a | load_b;
  assign last     = (idx == IW'(N - 1));
  assign arith    = ~op_q[2];
  assign a_ch     = a_q[idx*CHUNK +: CHUNK];
  assign b_ch     = b_q[idx*CHUNK +: CHUNK];

  alu_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a        (a_ch),
    .b        (b_ch),
    .op       (op_q),
    .cin      (carry_q),
    .y        (y_ch),
    .cout     (cout_ch),
    .c_msb_in (cmsb_ch)
  );

  // Full result as it would stand after this edge: finished chunks plus the live one.
  always_comb begin
    res                    = s_q;
    res[idx*CHUNK +: CHUNK] = y_ch;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && !load_any) state_nxt = ST_BUSY;
      ST_BUSY: if (last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      done_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load_any) begin
            if (load_a) a_q <= bus_in;
            if (load_b) b_q <= bus_in;
          end else if (start) begin
            op_q    <= op_e'(op);
            carry_q <= cin_for(op_e'(op), flags_q[FLAG_C]);
            zacc_q  <= 1'b1;
            idx     <= '0;
          end
        end
        ST_BUSY: begin
          s_q     <= res;
          carry_q <= cout_ch;
          zacc_q  <= zacc_q & ~|y_ch;
          idx     <= idx + 1'b1;
          if (last) begin
            a_q             <= res;
            idx             <= '0;
            done_q          <= 1'b1;
            flags_q[FLAG_C] <= arith & cout_ch;
            flags_q[FLAG_Z] <= zacc_q & ~|y_ch;
`ifdef ACC_ALU_SIGNED_FLAGS_EN
            flags_q[FLAG_N] <= res[WIDTH-1];
            flags_q[FLAG_V] <= arith & (cmsb_ch ^ cout_ch);
`else
            flags_q[FLAG_N] <= 1'b0;
            flags_q[FLAG_V] <= cmsb_ch;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_out = a_q;
  assign ready   = (state == ST_IDLE);
  assign bus_oe  = out_en & ready;
  assign done    = done_q;
  assign cf      = flags_q[FLAG_C];
  assign zf      = flags_q[FLAG_Z];
  assign nf      = flags_q[FLAG_N];
  assign vf      = flags_q[FLAG_V];

endmodule
